// File: rtl/vx_warp_fetch_sched.sv
// vx_warp_fetch_sched: warp scheduler feeding instruction fetch.
// Keeps per-warp active/stall/PC/tmask state, picks one ready warp per cycle
// round-robin and presents {wid, pc, tmask, uuid} over a valid/ready port.
// An issued warp stays stalled until decode unlocks it or a branch/tmc resolves it.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wspawn_*            spawn inactive warps in wspawn_wmask at wspawn_pc
//   tmc_*               thread-mask change (all-zero mask deactivates), unlocks
//   branch_*            branch resolution, unlocks, optional redirect
//   unlock_*            decode unlock for non-control instructions
//   sched_*             schedule output to fetch (valid/ready)
//   busy                any warp active or an entry pending
module vx_warp_fetch_sched #(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_THREADS  = 4,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned UUID_WIDTH   = 44,
  parameter logic [XLEN-1:0] STARTUP_ADDR = XLEN'(32'h80000000),
  localparam int unsigned NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wspawn_valid,
  input  logic [NUM_WARPS-1:0]   wspawn_wmask,
  input  logic [XLEN-1:0]        wspawn_pc,
  input  logic                   tmc_valid,
  input  logic [NW_W-1:0]        tmc_wid,
  input  logic [NUM_THREADS-1:0] tmc_tmask,
  input  logic                   branch_valid,
  input  logic [NW_W-1:0]        branch_wid,
  input  logic                   branch_taken,
  input  logic [XLEN-1:0]        branch_dest,
  input  logic                   unlock_valid,
  input  logic [NW_W-1:0]        unlock_wid,
  output logic                   sched_valid,
  output logic [NW_W-1:0]        sched_wid,
  output logic [XLEN-1:0]        sched_pc,
  output logic [NUM_THREADS-1:0] sched_tmask,
  output logic [UUID_WIDTH-1:0]  sched_uuid,
  input  logic                   sched_ready,
  output logic                   busy
);

  logic [NUM_WARPS-1:0]   active_q, active_d;
  logic [NUM_WARPS-1:0]   stall_q, stall_d;
  logic [XLEN-1:0]        pc_q [NUM_WARPS];
  logic [XLEN-1:0]        pc_d [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
  logic [NW_W-1:0]        rr_q, rr_d;
  logic [UUID_WIDTH-1:0]  uuid_q, uuid_d;

  logic                   sched_valid_q, sched_valid_d;
  logic [NW_W-1:0]        sched_wid_q, sched_wid_d;
  logic [XLEN-1:0]        sched_pc_q, sched_pc_d;
  logic [NUM_THREADS-1:0] sched_tmask_q, sched_tmask_d;
  logic [UUID_WIDTH-1:0]  sched_uuid_q, sched_uuid_d;
  logic                   busy_q, busy_d;

  logic [NUM_WARPS-1:0]   ready_set;
  logic                   pick_found;
  logic [NW_W-1:0]        pick_wid;
  int unsigned            idx;
  logic                   issue;
  logic                   branch_en;
  logic                   unlock_en;

  assign ready_set = active_q & ~stall_q;

  // Round-robin pick: first ready warp at or after rr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_wid   = '0;
    idx        = 0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
      if (!pick_found && ready_set[NW_W'(idx)]) begin
        pick_found = 1'b1;
        pick_wid   = NW_W'(idx);
      end
    end
  end

  assign issue = (!sched_valid_q || sched_ready) && pick_found;

  // Same-wid priority: tmc drops branch and unlock, branch drops unlock.
  assign branch_en = branch_valid && !(tmc_valid && (tmc_wid == branch_wid));
  assign unlock_en = unlock_valid && !(tmc_valid && (tmc_wid == unlock_wid))
                                  && !(branch_en && (branch_wid == unlock_wid));

  // Next-state: issue first, then spawn and resolution events.
  always_comb begin
    active_d      = active_q;
    stall_d       = stall_q;
    pc_d          = pc_q;
    tmask_d       = tmask_q;
    rr_d          = rr_q;
    uuid_d        = uuid_q;
    sched_valid_d = sched_valid_q;
    sched_wid_d   = sched_wid_q;
    sched_pc_d    = sched_pc_q;
    sched_tmask_d = sched_tmask_q;
    sched_uuid_d  = sched_uuid_q;

    if (issue) begin
      sched_valid_d     = 1'b1;
      sched_wid_d       = pick_wid;
      sched_pc_d        = pc_q[pick_wid];
      sched_tmask_d     = tmask_q[pick_wid];
      sched_uuid_d      = uuid_q;
      stall_d[pick_wid] = 1'b1;
      pc_d[pick_wid]    = pc_q[pick_wid] + XLEN'(4);
      rr_d              = (pick_wid == NW_W'(NUM_WARPS - 1)) ? '0 : pick_wid + NW_W'(1);
      uuid_d            = uuid_q + UUID_WIDTH'(1);
    end else if (sched_ready) begin
      sched_valid_d = 1'b0;
    end

    if (wspawn_valid) begin
      for (int unsigned i = 0; i < NUM_WARPS; i++) begin
        if (wspawn_wmask[i] && !active_q[i]) begin
          active_d[i] = 1'b1;
          pc_d[i]     = wspawn_pc;
          tmask_d[i]  = NUM_THREADS'(1);
          stall_d[i]  = 1'b0;
        end
      end
    end

    // A warp issued this cycle keeps its new stall; stray releases are ignored.
    if (unlock_en && !(issue && pick_wid == unlock_wid)) begin
      stall_d[unlock_wid] = 1'b0;
    end

    if (branch_en) begin
      if (!(issue && pick_wid == branch_wid)) stall_d[branch_wid] = 1'b0;
      if (branch_taken) pc_d[branch_wid] = branch_dest;
    end

    if (tmc_valid) begin
      if (!(issue && pick_wid == tmc_wid)) stall_d[tmc_wid] = 1'b0;
      tmask_d[tmc_wid] = tmc_tmask;
      if (tmc_tmask == '0) active_d[tmc_wid] = 1'b0;
    end

    busy_d = (|active_d) || sched_valid_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q      <= NUM_WARPS'(1);
      stall_q       <= '0;
      for (int unsigned i = 0; i < NUM_WARPS; i++) begin
        pc_q[i]    <= (i == 0) ? STARTUP_ADDR : '0;
        tmask_q[i] <= (i == 0) ? NUM_THREADS'(1) : '0;
      end
      rr_q          <= '0;
      uuid_q        <= '0;
      sched_valid_q <= 1'b0;
      sched_wid_q   <= '0;
      sched_pc_q    <= '0;
      sched_tmask_q <= '0;
      sched_uuid_q  <= '0;
      busy_q        <= 1'b1;
    end else begin
      active_q      <= active_d;
      stall_q       <= stall_d;
      pc_q          <= pc_d;
      tmask_q       <= tmask_d;
      rr_q          <= rr_d;
      uuid_q        <= uuid_d;
      sched_valid_q <= sched_valid_d;
      sched_wid_q   <= sched_wid_d;
      sched_pc_q    <= sched_pc_d;
      sched_tmask_q <= sched_tmask_d;
      sched_uuid_q  <= sched_uuid_d;
      busy_q        <= busy_d;
    end
  end

  assign sched_valid = sched_valid_q;
  assign sched_wid   = sched_wid_q;
  assign sched_pc    = sched_pc_q;
  assign sched_tmask = sched_tmask_q;
  assign sched_uuid  = sched_uuid_q;
  assign busy        = busy_q;

endmodule
